effect_looper: RTL

Single-track loop recorder/player at the tail of the effect chain: consumes the final effect output (`o_data`/`o_valid` of the tremolo stage) and produces the sample stream fed to the DAC player. It records the processed stream into the external 1M×16 SRAM and plays the loop back mixed with live input. It also owns the SRAM read/write sequencing, one access per sample. Top-level FSM keys (record/play loop) drive it through single-cycle pulses.

---
 rtl/effect_looper.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/effect_looper.sv
// effect_looper
// -----------------------------------------------------------------------------
// Single-track loop recorder/player at the tail of the effect chain. Records the
// processed sample stream into an external asynchronous SRAM and plays the loop
// back mixed 1:1 with the live input. It owns the SRAM access sequencing and
// performs one access per sample.
//
// Ports
//   i_clk, i_rst         : bit clock; synchronous active-high reset
//   i_valid, i_data      : input sample strobe and signed sample
//   i_rec_toggle         : single-cycle key pulse, IDLE->RECORD->PLAY->IDLE
//   i_clear              : synchronous clear of loop and state (same as reset)
//   o_data, o_valid      : output sample (held) and its single-cycle strobe
//   o_state              : 0 = IDLE, 1 = RECORD, 2 = PLAY
//   o_sram_addr          : SRAM address, held for the two access cycles
//   o_sram_wdata         : write data, driven onto DQ while o_sram_dq_oe = 1
//   o_sram_dq_oe         : DQ output enable
//   o_sram_we_n          : active-low write enable
//   o_sram_oe_n          : active-low output enable
//   i_sram_rdata         : DQ read value
//
// Handshake: i_valid is a strobe with no back-pressure. A strobe is accepted
// only while the access sequencer is in PH_WAIT; one arriving during the three
// busy cycles of a previous sample is dropped and produces no output. Every
// accepted strobe at cycle T yields exactly one o_valid at T+3 unless cleared.
// -----------------------------------------------------------------------------
module effect_looper #(
  parameter int ADDR_W  = 20,
  parameter int MAX_LEN = 2**20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [15:0]       i_data,
  input  logic              i_rec_toggle,
  input  logic              i_clear,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_dq_oe,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  input  logic [15:0]       i_sram_rdata
);

  // One extra bit so a completely full loop length (MAX_LEN) is representable.
  localparam int               LEN_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RECORD = 2'd1,
    MODE_PLAY   = 2'd2
  } mode_t;

  // Access sequencer: WAIT is cycle T, ADDR is T+1, HOLD is T+2, OUT is T+3.
  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_ADDR = 2'd1,
    PH_HOLD = 2'd2,
    PH_OUT  = 2'd3
  } phase_t;

  mode_t             mode;
  mode_t             mode_nxt;
  mode_t             acc_mode;
  phase_t            phase;
  logic              pending;
  logic              take;
  logic [LEN_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]  rd_ptr;
  logic [LEN_W-1:0]  loop_len;
  logic [15:0]       sample;
  logic [ADDR_W-1:0] acc_addr;
  logic signed [16:0] mix_sum;

  function automatic logic [15:0] sat16(input logic signed [16:0] s);
    if (s > 17'sd32767)
      return 16'h7fff;
    else if (s < -17'sd32768)
      return 16'h8000;
    else
      return s[15:0];
  endfunction

  // A toggle arriving together with the strobe counts as already pending.
  always_comb begin
    take     = pending | i_rec_toggle;
    mode_nxt = mode;
    if (take) begin
      case (mode)
        MODE_IDLE:   mode_nxt = MODE_RECORD;
        MODE_RECORD: mode_nxt = (wr_ptr == '0) ? MODE_IDLE : MODE_PLAY;
        default:     mode_nxt = MODE_IDLE;
      endcase
    end
  end

  // Entering RECORD or PLAY restarts at address 0; staying uses the pointer.
  always_comb begin
    acc_addr = '0;
    if (mode_nxt == MODE_RECORD && mode == MODE_RECORD)
      acc_addr = wr_ptr[ADDR_W-1:0];
    else if (mode_nxt == MODE_PLAY && mode == MODE_PLAY)
      acc_addr = rd_ptr[ADDR_W-1:0];
  end

  assign mix_sum = $signed({sample[15], sample}) + $signed({i_sram_rdata[15], i_sram_rdata});
  assign o_state = mode;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      mode         <= MODE_IDLE;
      acc_mode     <= MODE_IDLE;
      phase        <= PH_WAIT;
      pending      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      loop_len     <= '0;
      sample       <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      if (i_rec_toggle)
        pending <= 1'b1;

      case (phase)
        PH_WAIT: begin
          if (i_valid) begin
            // Consumed here; overrides a toggle arriving in this same cycle,
            // which has already been folded into mode_nxt.
            pending  <= 1'b0;
            mode     <= mode_nxt;
            acc_mode <= mode_nxt;
            sample   <= i_data;
            if (mode_nxt == MODE_RECORD && mode != MODE_RECORD)
              wr_ptr <= '0;
            if (mode_nxt == MODE_PLAY && mode != MODE_PLAY) begin
              loop_len <= wr_ptr;
              rd_ptr   <= '0;
            end
            case (mode_nxt)
              MODE_RECORD: begin
                o_sram_addr  <= acc_addr;
                o_sram_wdata <= i_data;
                o_sram_dq_oe <= 1'b1;
                o_sram_we_n  <= 1'b0;
              end
              MODE_PLAY: begin
                o_sram_addr <= acc_addr;
                o_sram_oe_n <= 1'b0;
              end
              default: ;
            endcase
            phase <= PH_ADDR;
          end
        end

        PH_ADDR: begin
          // Release WE while address and data stay put for hold time.
          o_sram_we_n <= 1'b1;
          phase       <= PH_HOLD;
        end

        PH_HOLD: begin
          o_sram_dq_oe <= 1'b0;
          o_sram_oe_n  <= 1'b1;
          o_valid      <= 1'b1;
          if (acc_mode == MODE_PLAY)
            o_data <= sat16(mix_sum);
          else
            o_data <= sample;

          if (acc_mode == MODE_RECORD) begin
            wr_ptr <= wr_ptr + 1'b1;
            // The last address was just written: the loop is full, so the
            // next sample already plays from the start.
            if (wr_ptr == LAST_ADDR) begin
              mode     <= MODE_PLAY;
              loop_len <= FULL_LEN;
              rd_ptr   <= '0;
            end
          end else if (acc_mode == MODE_PLAY) begin
            if (rd_ptr == loop_len - 1'b1)
              rd_ptr <= '0;
            else
              rd_ptr <= rd_ptr + 1'b1;
          end
          phase <= PH_OUT;
        end

        default: begin
          phase <= PH_WAIT;
        end
      endcase
    end
  end

endmodule
